// File: rtl/coeff_stream_sink_if.sv
`default_nettype none
// ============================================================================
// Module      : coeff_stream_sink_if
// Description : ap_fifo-style read interface carrying coefficient words from
//               the weight streamer FIFO to the coefficient sink.
//               The master side is the FIFO and the slave side is the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface coeff_stream_sink_if #(
  parameter int COEFF_WIDTH = 16
);

  logic [COEFF_WIDTH-1:0] input_V_dout;     // FIFO head word
  logic                   input_V_empty_n;  // FIFO holds at least one word
  logic                   input_V_read;     // pop strobe from the consumer

  // FIFO side: presents data and the non-empty flag, and observes the pop strobe
  modport master (
    output input_V_dout,
    output input_V_empty_n,
    input  input_V_read
  );

  // Consumer side: observes data and the non-empty flag, and drives the pop strobe
  modport slave (
    input  input_V_dout,
    input  input_V_empty_n,
    output input_V_read
  );

endinterface
`default_nettype wire

// File: rtl/coeff_stream_sink.sv
`default_nettype none
// ============================================================================
// Module      : coeff_stream_sink
// Description : Drains exactly KERN_SIZE coefficients from an ap_fifo stream
//               into local RAM, then serves them through a ROM-like port
//               with a 1-cycle read latency. A reload pulse in DONE restarts
//               the load so that a new kernel can be streamed in.
//               Optional macro COEFF_STREAM_SINK_CHECKSUM_EN adds a
//               load_checksum output (running XOR of the current load).
// Revision    : 1.0 - initial release
// ============================================================================
module coeff_stream_sink #(
  parameter  int KERN_SIZE   = 288,
  parameter  int COEFF_WIDTH = 16,
  localparam int AW          = (KERN_SIZE > 1) ? $clog2(KERN_SIZE) : 1
) (
  input  wire logic                   ap_clk,
  input  wire logic                   ap_rst,
  coeff_stream_sink_if.slave          fifo,
  input  wire logic [AW-1:0]          weight_address,
  input  wire logic                   weight_ce,
  output logic      [COEFF_WIDTH-1:0] weight_q,
  input  wire logic                   reload,
  output logic                        loaded
`ifdef COEFF_STREAM_SINK_CHECKSUM_EN
  ,
  output logic      [COEFF_WIDTH-1:0] load_checksum
`endif
);

  // Index of the final word of a load, and the RAM depth widened so that
  // every address value can be compared against it.
  localparam logic [AW-1:0] LAST_IDX = AW'(KERN_SIZE - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(KERN_SIZE);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [AW-1:0]          r_wr_cnt;
  logic [AW-1:0]          w_wr_cnt_nxt;
  logic                   w_read;
  logic                   w_xfer;
  logic                   w_rd_in_range;

  logic [COEFF_WIDTH-1:0] mem [KERN_SIZE];

  // Pop strobe depends only on the registered state and the FIFO flag.
  assign fifo.input_V_read = w_read;

  // The RAM holds a complete kernel exactly while the FSM sits in DONE.
  assign loaded = (r_state == S_DONE);

  // Addresses beyond the kernel read back as zero instead of stale data.
  assign w_rd_in_range = ({1'b0, weight_address} < DEPTH);

  // Next-state, write-counter and pop-strobe decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_cnt_nxt = r_wr_cnt;
    w_read       = 1'b0;
    w_xfer       = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_read = fifo.input_V_empty_n;
        w_xfer = fifo.input_V_empty_n;
        if (fifo.input_V_empty_n) begin
          if (r_wr_cnt == LAST_IDX) begin
            // Final word: stop popping; a same-cycle reload is not looked at.
            w_state_nxt  = S_DONE;
            w_wr_cnt_nxt = '0;
          end else begin
            w_wr_cnt_nxt = r_wr_cnt + AW'(1);
          end
        end
      end
      S_DONE: begin
        if (reload) begin
          w_state_nxt  = S_LOAD;
          w_wr_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = S_LOAD;
        w_wr_cnt_nxt = '0;
      end
    endcase
  end

  // State and write-counter registers; reset abandons any partial load.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state  <= S_LOAD;
      r_wr_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
    end
  end

  // RAM write port: one word per FIFO transfer; contents survive reset.
  always_ff @(posedge ap_clk) begin
    if (w_xfer) begin
      mem[r_wr_cnt] <= fifo.input_V_dout;
    end
  end

  // Registered read port; the old word is returned on a same-address write.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      weight_q <= '0;
    end else if (weight_ce) begin
      weight_q <= w_rd_in_range ? mem[weight_address] : '0;
    end
  end

`ifdef COEFF_STREAM_SINK_CHECKSUM_EN
  logic [COEFF_WIDTH-1:0] r_checksum;

  assign load_checksum = r_checksum;

  // Running XOR of the words of the current load, restarted by reload.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_checksum <= '0;
    end else if ((r_state == S_DONE) && reload) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum ^ fifo.input_V_dout;
    end
  end
`endif

endmodule
`default_nettype wire
